// File: rtl/obd_telemetry_tx.sv
// obd_telemetry_tx: snapshots vehicle state and sends it as a 12-byte UART 8N1 frame
module obd_telemetry_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        engine_on,
   input  logic        tick_1sec,
   input  logic        send_req,
   input  logic [7:0]  speed,
   input  logic [13:0] rpm,
   input  logic [7:0]  fuel,
   input  logic [7:0]  temp,
   input  logic [31:0] odometer_raw,
   input  logic        ess_trigger,
   input  logic [2:0]  gear_num,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [3:0] byte_q, byte_d;
   logic [11:0][7:0] frame_q, frame_d, snap;
   logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, pending_q, pending_d, overrun_q, overrun_d;
   logic trig, bit_end, last_end;
   logic [7:0] status;
   assign trig = send_req | (tick_1sec & engine_on);
   assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
   assign last_end = state_q == STOP && bit_end && byte_q == 4'd11;
   assign status = {engine_on, ess_trigger, 3'b000, gear_num};
   assign tx = tx_q;
   assign busy = busy_q;
   assign frame_done = done_q;
   assign overrun = overrun_q;
   // live frame image, latched into frame_q only when a frame starts
   always_comb begin
      snap[0] = SYNC_BYTE;
      snap[1] = speed;
      snap[2] = {2'b00, rpm[13:8]};
      snap[3] = rpm[7:0];
      snap[4] = fuel;
      snap[5] = temp;
      snap[6] = odometer_raw[31:24];
      snap[7] = odometer_raw[23:16];
      snap[8] = odometer_raw[15:8];
      snap[9] = odometer_raw[7:0];
      snap[10] = status;
      snap[11] = speed ^ {2'b00, rpm[13:8]} ^ rpm[7:0] ^ fuel ^ temp ^ odometer_raw[31:24]
               ^ odometer_raw[23:16] ^ odometer_raw[15:8] ^ odometer_raw[7:0] ^ status;
   end
   // frame sequencing, bit timing and trigger queueing
   always_comb begin
      state_d = state_q;
      cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      bit_d = bit_q;
      byte_d = byte_q;
      frame_d = frame_q;
      tx_d = tx_q;
      busy_d = busy_q;
      done_d = 1'b0;
      pending_d = pending_q;
      overrun_d = overrun_q;
      if (state_q != IDLE && !last_end && trig) begin
         overrun_d = overrun_q | pending_q;
         pending_d = 1'b1;
      end
      if (state_q == IDLE && trig) begin
         frame_d = snap;
         byte_d = 4'd0;
         state_d = START;
         tx_d = 1'b0;
         busy_d = 1'b1;
      end else if (state_q == START && bit_end) begin
         state_d = DATA;
         bit_d = 3'd0;
         tx_d = frame_q[byte_q][0];
      end else if (state_q == DATA && bit_end) begin
         bit_d = bit_q + 3'd1;
         state_d = bit_q == 3'd7 ? STOP : DATA;
         tx_d = bit_q == 3'd7 ? 1'b1 : frame_q[byte_q][bit_d];
      end else if (state_q == STOP && bit_end && !last_end) begin
         byte_d = byte_q + 4'd1;
         state_d = START;
         tx_d = 1'b0;
      end else if (last_end) begin
         done_d = 1'b1;
         pending_d = 1'b0;
         frame_d = snap;
         byte_d = 4'd0;
         state_d = (pending_q | trig) ? START : IDLE;
         tx_d = !(pending_q | trig);
         busy_d = pending_q | trig;
      end
   end
   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         bit_q <= 3'd0;
         byte_q <= 4'd0;
         frame_q <= '0;
         tx_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         byte_q <= byte_d;
         frame_q <= frame_d;
         tx_q <= tx_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end
endmodule
